vc_fifo: RTL and testbench
==========================

VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent channel queues, at least 1.
REQ-002 Parameter DATA_WIDTH, default 32: payload width in bits.
REQ-003 Parameter DEPTH, default 4: entries per channel, at least 2.
REQ-004 Parameter AF_THRESH, default DEPTH-1: almost-full level, 1..DEPTH.
REQ-005 Derived widths SHALL be CW = (NUM_CH>1) ? $clog2(NUM_CH) : 1 and AW = $clog2(DEPTH), and SHALL NOT be overridden.
REQ-006 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst_ni, input, 1: reset, synchronous and active-low.
REQ-008 Port flush_i, input, 1: synchronous clear of all channels.
REQ-009 Ports in_valid_i (input, 1), in_ch_i (input, CW), in_data_i (input, DATA_WIDTH), in_ready_o (output, 1): push channel.
REQ-010 Ports out_valid_o (output, 1), out_ch_o (output, CW), out_data_o (output, DATA_WIDTH), out_ready_i (input, 1): pop channel.
REQ-011 Ports full_o, empty_o, almost_full_o (each output, NUM_CH): per-channel status, bit c for channel c.
REQ-012 Port usage_o, output, NUM_CH*(AW+1): per-channel occupancy; channel c occupies bits [c*(AW+1) +: AW+1].

Function
REQ-013 Each channel SHALL be an independent circular buffer of DEPTH entries with a read pointer, a write pointer and an AW+1-bit count.
REQ-014 Each pointer SHALL wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-015 Status outputs SHALL be derived from the registered count: full_o[c] at count==DEPTH; empty_o[c] at count==0; almost_full_o[c] at count>=AF_THRESH.
REQ-016 in_ready_o SHALL be 1 only when flush_i=0, in_ch_i<NUM_CH and full_o[in_ch_i]=0.
REQ-017 A push SHALL occur when in_valid_i and in_ready_o are both 1; it writes in_data_i at the write pointer of channel in_ch_i, then increments that pointer and count.
REQ-018 A push to an out-of-range channel index SHALL be dropped with no state change.
REQ-019 Arbitration SHALL be round-robin over non-empty channels, searching upward (with wrap) from a priority pointer rr_q, which resets to 0.
REQ-020 out_valid_o SHALL be 1 when any channel is non-empty and flush_i=0.
REQ-021 out_ch_o SHALL be the granted channel and out_data_o that channel's head entry.
REQ-022 A pop SHALL occur when out_valid_o and out_ready_i are both 1; it advances the granted channel's read pointer, decrements its count and sets rr_q to (grant+1) mod NUM_CH.
REQ-023 A grant SHALL be locked while out_valid_o=1 and out_ready_i=0: out_ch_o and out_data_o hold stable until accepted, regardless of pushes to other channels.
REQ-024 Minimum latency SHALL be one cycle: data pushed in cycle t is first visible on the output in cycle t+1; there is no fall-through.
REQ-025 A simultaneous push and pop on the same channel SHALL leave its count unchanged and advance both pointers.
REQ-026 A push on a full channel SHALL NOT be accepted, even when that channel is popped in the same cycle.
REQ-027 Simultaneous push and pop on different channels SHALL update each channel independently.
REQ-028 flush_i=1 SHALL drop any push or pop in that cycle and clear all pointers, counts, rr_q and the grant lock on the next edge; stored data contents are don't-care.

Reset
REQ-029 While rst_ni=0 at a rising edge, all pointers, counts, rr_q and the lock SHALL clear.
REQ-030 After reset: out_valid_o=0, empty_o all ones, full_o=0, almost_full_o=0, usage_o=0, and in_ready_o=1 for a valid in_ch_i.
REQ-031 Reset asserted mid-transfer SHALL discard all queued data; the first cycle after release behaves as post-reset.

Verification
REQ-032 Scenario: NUM_CH=2, DEPTH=4. Push A,B,C,D to ch0 -> full_o[0]=1, in_ready_o=0 on ch0, usage ch0=4; pops return A,B,C,D in order.
REQ-033 Scenario: DEPTH=3. Six alternating push/pop on ch1 -> pointers wrap, data order preserved, count never exceeds 1.
REQ-034 Scenario: ch0 and ch1 each hold 2 entries, out_ready_i=1 -> out_ch_o sequence 0,1,0,1.
REQ-035 Scenario: out_ready_i=0 for 3 cycles while ch1 receives pushes -> out_ch_o and out_data_o unchanged.
REQ-036 Scenario: ch0 full, push and pop ch0 in the same cycle -> push rejected, usage ch0 becomes 3.
REQ-037 Scenario: flush_i pulsed with entries queued -> next cycle empty_o all ones and out_valid_o=0; same-cycle push lost. rst_ni=0 for 1 cycle mid-stream -> REQ-030 state.

Source files
------------

// File: rtl/vc_fifo.sv
// Multi-channel FIFO: NUM_CH independent circular queues share one push port and one pop
// port; the pop side serves non-empty channels round-robin and locks a grant until accepted.
module vc_fifo #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AF_THRESH  = DEPTH - 1,
   localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   input  logic [CW-1:0]              in_ch_i,
   input  logic [DATA_WIDTH-1:0]      in_data_i,
   output logic                       in_ready_o,
   output logic                       out_valid_o,
   output logic [CW-1:0]              out_ch_o,
   output logic [DATA_WIDTH-1:0]      out_data_o,
   input  logic                       out_ready_i,
   output logic [NUM_CH-1:0]          full_o,
   output logic [NUM_CH-1:0]          empty_o,
   output logic [NUM_CH-1:0]          almost_full_o,
   output logic [NUM_CH*(AW+1)-1:0]   usage_o
);

   localparam int unsigned CNTW = AW + 1;

   logic [AW-1:0]         rptr_q [NUM_CH];
   logic [AW-1:0]         rptr_d [NUM_CH];
   logic [AW-1:0]         wptr_q [NUM_CH];
   logic [AW-1:0]         wptr_d [NUM_CH];
   logic [CNTW-1:0]       cnt_q  [NUM_CH];
   logic [CNTW-1:0]       cnt_d  [NUM_CH];
   logic [DATA_WIDTH-1:0] mem_q  [NUM_CH][DEPTH];

   logic [CW-1:0]     rr_q, rr_d;
   logic [CW-1:0]     lock_ch_q, lock_ch_d;
   logic              lock_q, lock_d;
   logic [CW-1:0]     arb_ch, grant;
   logic              arb_found;
   logic              in_range, in_full;
   logic              push, pop;
   logic [NUM_CH-1:0] push_en, pop_en;
   int unsigned       idx;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      full_o        = '0;
      empty_o       = '0;
      almost_full_o = '0;
      usage_o       = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         full_o[c]                  = (cnt_q[c] == CNTW'(DEPTH));
         empty_o[c]                 = (cnt_q[c] == '0);
         almost_full_o[c]           = (cnt_q[c] >= CNTW'(AF_THRESH));
         usage_o[c*CNTW +: CNTW]    = cnt_q[c];
      end
   end

   always_comb begin
      in_range = (32'(in_ch_i) < NUM_CH);
      in_full  = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (in_ch_i == CW'(c)) in_full = full_o[c];
      end
      in_ready_o = !flush_i && in_range && !in_full;
      push       = in_valid_i && in_ready_o;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         push_en[c] = push && (in_ch_i == CW'(c));
      end
   end

   // Round-robin search upward from rr_q; a held grant overrides the search.
   always_comb begin
      arb_found = 1'b0;
      arb_ch    = rr_q;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = (32'(rr_q) + i) % NUM_CH;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!arb_found && (c == idx) && !empty_o[c]) begin
               arb_found = 1'b1;
               arb_ch    = CW'(c);
            end
         end
      end
      grant = lock_q ? lock_ch_q : arb_ch;
   end

   always_comb begin
      out_valid_o = !flush_i && !(&empty_o);
      out_ch_o    = grant;
      out_data_o  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (grant == CW'(c)) out_data_o = mem_q[c][rptr_q[c]];
      end
      pop = out_valid_o && out_ready_i;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         pop_en[c] = pop && (grant == CW'(c));
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         rptr_d[c] = rptr_q[c];
         wptr_d[c] = wptr_q[c];
         cnt_d[c]  = cnt_q[c];
      end
      rr_d      = rr_q;
      lock_d    = lock_q;
      lock_ch_d = lock_ch_q;
      if (flush_i) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rptr_d[c] = '0;
            wptr_d[c] = '0;
            cnt_d[c]  = '0;
         end
         rr_d      = '0;
         lock_d    = 1'b0;
         lock_ch_d = '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push_en[c]) wptr_d[c] = ptr_inc(wptr_q[c]);
            if (pop_en[c])  rptr_d[c] = ptr_inc(rptr_q[c]);
            unique case ({push_en[c], pop_en[c]})
               2'b10:   cnt_d[c] = cnt_q[c] + CNTW'(1);
               2'b01:   cnt_d[c] = cnt_q[c] - CNTW'(1);
               default: cnt_d[c] = cnt_q[c];
            endcase
         end
         if (pop) rr_d = (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
         lock_d    = out_valid_o && !out_ready_i;
         lock_ch_d = grant;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rptr_q[c] <= '0;
            wptr_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         rr_q      <= '0;
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rptr_q[c] <= rptr_d[c];
            wptr_q[c] <= wptr_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
      end
   end

   // Storage has no reset; contents are only meaningful below the count.
   always_ff @(posedge clk_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (push_en[c]) mem_q[c][wptr_q[c]] <= in_data_i;
      end
   end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo: stimulus queues expected pops, per-DUT monitors compare them.
// DUT a is NUM_CH=2/DEPTH=4, DUT b is NUM_CH=3/DEPTH=3 for wrap and out-of-range cases.
module tb_vc_fifo;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [0:0]  a_in_ch, a_out_ch;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_full, a_empty, a_af;
   logic [5:0]  a_usage;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [1:0]  b_in_ch, b_out_ch;
   logic [31:0] b_in_data, b_out_data;
   logic [2:0]  b_full, b_empty, b_af;
   logic [8:0]  b_usage;

   vc_fifo #(.NUM_CH(2), .DATA_WIDTH(32), .DEPTH(4)) u_dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (a_flush),
      .in_valid_i   (a_in_valid),
      .in_ch_i      (a_in_ch),
      .in_data_i    (a_in_data),
      .in_ready_o   (a_in_ready),
      .out_valid_o  (a_out_valid),
      .out_ch_o     (a_out_ch),
      .out_data_o   (a_out_data),
      .out_ready_i  (a_out_ready),
      .full_o       (a_full),
      .empty_o      (a_empty),
      .almost_full_o(a_af),
      .usage_o      (a_usage)
   );

   vc_fifo #(.NUM_CH(3), .DATA_WIDTH(32), .DEPTH(3)) u_dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (b_flush),
      .in_valid_i   (b_in_valid),
      .in_ch_i      (b_in_ch),
      .in_data_i    (b_in_data),
      .in_ready_o   (b_in_ready),
      .out_valid_o  (b_out_valid),
      .out_ch_o     (b_out_ch),
      .out_data_o   (b_out_data),
      .out_ready_i  (b_out_ready),
      .full_o       (b_full),
      .empty_o      (b_empty),
      .almost_full_o(b_af),
      .usage_o      (b_usage)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, tmp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_pop: got ch %0d data %0h expected none",
                     a_out_ch, a_out_data);
         end else begin
            ea = qa.pop_front();
            check("a_pop_ch", 64'(a_out_ch), 64'(ea.ch));
            check("a_pop_data", 64'(a_out_data), 64'(ea.data));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_pop: got ch %0d data %0h expected none",
                     b_out_ch, b_out_data);
         end else begin
            eb = qb.pop_front();
            check("b_pop_ch", 64'(b_out_ch), 64'(eb.ch));
            check("b_pop_data", 64'(b_out_data), 64'(eb.data));
         end
      end
   end

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic a_step(input logic v, input logic [0:0] ch, input logic [31:0] d,
                         input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      a_in_valid  = v;
      a_in_ch     = ch;
      a_in_data   = d;
      a_out_ready = rdy;
      a_flush     = fl;
   endtask

   task automatic b_step(input logic v, input logic [1:0] ch, input logic [31:0] d,
                         input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      b_in_valid  = v;
      b_in_ch     = ch;
      b_in_data   = d;
      b_out_ready = rdy;
      b_flush     = fl;
   endtask

   task automatic a_expect(input logic [1:0] ch, input logic [31:0] d);
      tmp.ch   = ch;
      tmp.data = d;
      qa.push_back(tmp);
   endtask

   task automatic b_expect(input logic [1:0] ch, input logic [31:0] d);
      tmp.ch   = ch;
      tmp.data = d;
      qb.push_back(tmp);
   endtask

   task automatic a_check_idle(input string tag);
      check({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
      check({tag, "_empty"}, 64'(a_empty), 64'h3);
      check({tag, "_full"}, 64'(a_full), 64'd0);
      check({tag, "_af"}, 64'(a_af), 64'd0);
      check({tag, "_usage"}, 64'(a_usage), 64'd0);
      check({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_ch = '0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
      b_in_valid = 1'b0; b_in_ch = '0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      neg();
      a_check_idle("a_reset");
      check("b_reset_empty", 64'(b_empty), 64'h7);
      check("b_reset_usage", 64'(b_usage), 64'd0);
      check("b_reset_out_valid", 64'(b_out_valid), 64'd0);

      // Fill ch0, then push+pop on the full channel.
      for (int i = 0; i < 4; i++) begin
         a_step(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0, 1'b0);
         a_expect(2'd0, 32'hA0 + 32'(i));
         if (i == 0) begin
            neg();
            check("a_no_fallthrough", 64'(a_out_valid), 64'd0);
         end
      end
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_full_ch0", 64'(a_full), 64'h1);
      check("a_empty_ch1_only", 64'(a_empty), 64'h2);
      check("a_af_ch0", 64'(a_af), 64'h1);
      check("a_usage_ch0_4", 64'(a_usage[2:0]), 64'd4);
      check("a_in_ready_full", 64'(a_in_ready), 64'd0);
      check("a_head_data", 64'(a_out_data), 64'hA0);
      a_step(1'b1, 1'b0, 32'hEE, 1'b1, 1'b0);
      neg();
      check("a_push_full_rejected", 64'(a_in_ready), 64'd0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_usage_ch0_3", 64'(a_usage[2:0]), 64'd3);
      check("a_not_full", 64'(a_full), 64'd0);
      check("a_af_at_3", 64'(a_af), 64'h1);
      repeat (3) a_step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_drained_empty", 64'(a_empty), 64'h3);

      // Flush with entries queued and a push in the same cycle.
      a_step(1'b1, 1'b1, 32'hF0, 1'b0, 1'b0);
      a_step(1'b1, 1'b1, 32'hF1, 1'b0, 1'b0);
      a_step(1'b1, 1'b0, 32'hF2, 1'b0, 1'b1);
      neg();
      check("a_flush_in_ready", 64'(a_in_ready), 64'd0);
      check("a_flush_out_valid", 64'(a_out_valid), 64'd0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      a_check_idle("a_post_flush");

      // Round-robin over two loaded channels.
      a_step(1'b1, 1'b0, 32'h10, 1'b0, 1'b0); a_expect(2'd0, 32'h10);
      a_step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0); a_expect(2'd1, 32'h20);
      a_step(1'b1, 1'b0, 32'h11, 1'b0, 1'b0); a_expect(2'd0, 32'h11);
      a_step(1'b1, 1'b1, 32'h21, 1'b0, 1'b0); a_expect(2'd1, 32'h21);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_usage_2_2", 64'(a_usage), 64'h12);
      check("a_af_none", 64'(a_af), 64'd0);
      repeat (4) a_step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_rr_drained", 64'(a_empty), 64'h3);

      // Grant held while stalled, despite pushes to the other channel.
      a_step(1'b1, 1'b1, 32'h30, 1'b0, 1'b0); a_expect(2'd1, 32'h30);
      neg();
      check("a_latency_one_cycle", 64'(a_out_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         a_step(1'b1, 1'b0, 32'h40 + 32'(k), 1'b0, 1'b0);
         a_expect(2'd0, 32'h40 + 32'(k));
         neg();
         check("a_lock_ch", 64'(a_out_ch), 64'd1);
         check("a_lock_data", 64'(a_out_data), 64'h30);
      end
      repeat (4) a_step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      neg();
      check("a_lock_drained", 64'(a_empty), 64'h3);

      // Reset pulse mid-stream discards queued data.
      a_step(1'b1, 1'b0, 32'h50, 1'b0, 1'b0);
      a_step(1'b1, 1'b0, 32'h51, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      a_in_data = 32'h52;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a_in_valid = 1'b0;
      neg();
      a_check_idle("a_mid_reset");
      a_step(1'b1, 1'b1, 32'h60, 1'b0, 1'b0); a_expect(2'd1, 32'h60);
      a_step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      a_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

      // DUT b: out-of-range push, DEPTH=3 wrap, full on ch2.
      b_step(1'b1, 2'd3, 32'hBAD, 1'b0, 1'b0);
      neg();
      check("b_oor_in_ready", 64'(b_in_ready), 64'd0);
      b_step(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
      neg();
      check("b_oor_empty", 64'(b_empty), 64'h7);
      check("b_oor_usage", 64'(b_usage), 64'd0);
      for (int i = 0; i < 6; i++) begin
         b_step(1'b1, 2'd1, 32'hC0 + 32'(i), 1'b0, 1'b0);
         b_expect(2'd1, 32'hC0 + 32'(i));
         neg();
         check("b_wrap_usage_0", 64'(b_usage[5:3]), 64'd0);
         b_step(1'b0, 2'd1, 32'd0, 1'b1, 1'b0);
         neg();
         check("b_wrap_usage_1", 64'(b_usage[5:3]), 64'd1);
      end
      for (int i = 0; i < 3; i++) begin
         b_step(1'b1, 2'd2, 32'hD0 + 32'(i), 1'b0, 1'b0);
         b_expect(2'd2, 32'hD0 + 32'(i));
      end
      b_step(1'b0, 2'd2, 32'd0, 1'b0, 1'b0);
      neg();
      check("b_full_ch2", 64'(b_full), 64'h4);
      check("b_af_ch2", 64'(b_af), 64'h4);
      check("b_usage_ch2", 64'(b_usage[8:6]), 64'd3);
      check("b_in_ready_full", 64'(b_in_ready), 64'd0);
      repeat (3) b_step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
      b_step(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
      neg();
      check("b_drained_empty", 64'(b_empty), 64'h7);

      repeat (2) @(posedge clk);
      neg();
      check("a_scoreboard_drained", 64'(qa.size()), 64'd0);
      check("b_scoreboard_drained", 64'(qb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
